// File: rtl/mu0_ram_loader_if.sv
// Word stream + RAM write port + core control bundle for the MU0 RAM loader.
// Latency: n/a (signal bundle only).
// Backpressure: word_valid/word_ready handshake; the producer holds word_in until accepted.
//
// Ports (master = word producer / RAM+core side, slave = loader):
//   word_in, word_valid, run_req, reload  : master -> slave
//   word_ready, mem_addr, mem_wdata,
//   mem_we, mem_sel, cpu_reset,
//   word_count, full                      : slave -> master
interface mu0_ram_loader_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] word_in;
   logic              word_valid;
   logic              word_ready;
   logic              run_req;
   logic              reload;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_sel;
   logic              cpu_reset;
   logic [ADDR_W:0]   word_count;
   logic              full;

   modport master (
      output word_in, word_valid, run_req, reload,
      input  word_ready, mem_addr, mem_wdata, mem_we, mem_sel,
             cpu_reset, word_count, full
   );

   modport slave (
      input  word_in, word_valid, run_req, reload,
      output word_ready, mem_addr, mem_wdata, mem_we, mem_sel,
             cpu_reset, word_count, full
   );
endinterface

// File: rtl/mu0_ram_loader.sv
// Writes assembled MU0 words into program RAM from address 0, then hands RAM and reset to the core.
// Latency: word accepted at edge N -> mem_we high during cycle N+1; one word per 2 cycles.
// Backpressure: word_ready low during the write cycle, when full, and while the core runs.
//
// Ports:
//   clock  : rising-edge system clock
//   reset  : asynchronous active-high reset, clears all state
//   bus    : slave side of mu0_ram_loader_if (word stream in, RAM write port and core control out)
module mu0_ram_loader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input logic                clock,
   input logic                reset,
   mu0_ram_loader_if.slave    bus
);
   localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_WRITE = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_we;
   logic              r_mem_sel;
   logic              r_cpu_reset;
   logic              r_word_ready;
   logic [ADDR_W:0]   r_word_count;
   logic              r_full;

   // Ready is only ever set in LOAD; it already encodes ~full there.
   logic w_accept;
   assign w_accept = bus.word_valid & r_word_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_LOAD;
         r_wptr       <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_we     <= 1'b0;
         r_mem_sel    <= 1'b1;
         r_cpu_reset  <= 1'b1;
         r_word_ready <= 1'b1;
         r_word_count <= '0;
         r_full       <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               // A pending word beats run_req; run_req is a level and is seen again after the write.
               if (w_accept && r_state == S_LOAD) begin
                  r_mem_wdata  <= bus.word_in;
                  r_mem_addr   <= r_wptr;
                  r_mem_we     <= 1'b1;
                  r_word_ready <= 1'b0;
                  r_state      <= S_WRITE;
               end else if (bus.run_req) begin
                  r_cpu_reset  <= 1'b0;
                  r_mem_sel    <= 1'b0;
                  r_word_ready <= 1'b0;
                  r_state      <= S_RUN;
               end
            end
            S_WRITE: begin
               r_mem_we     <= 1'b0;
               r_word_count <= r_word_count + 1'b1;
               // Top location written: saturate instead of wrapping so MAX_ADDR is never overwritten.
               if (r_wptr == MAX_ADDR) begin
                  r_full       <= 1'b1;
                  r_word_ready <= 1'b0;
               end else begin
                  r_wptr       <= r_wptr + 1'b1;
                  r_word_ready <= 1'b1;
               end
               r_state <= S_LOAD;
            end
            S_RUN: begin
               // cpu_reset and mem_sel move together so the core never runs while the loader owns RAM.
               if (bus.reload) begin
                  r_wptr       <= '0;
                  r_word_count <= '0;
                  r_full       <= 1'b0;
                  r_cpu_reset  <= 1'b1;
                  r_mem_sel    <= 1'b1;
                  r_word_ready <= 1'b1;
                  r_state      <= S_LOAD;
               end
            end
            default: begin
               r_state <= S_LOAD;
            end
         endcase
      end
   end

   assign bus.word_ready = r_word_ready;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_sel    = r_mem_sel;
   assign bus.cpu_reset  = r_cpu_reset;
   assign bus.word_count = r_word_count;
   assign bus.full       = r_full;
endmodule

// File: doc/mu0_ram_loader.md
Name: mu0_ram_loader

Overview:
- Downstream of the byte-combining stage: takes each assembled 16-bit MU0 instruction/data word and writes it into consecutive locations of MU0 program RAM, starting at address 0.
- Owns the RAM write port and holds the MU0 core in reset while loading.
- On a run request it hands the RAM to the core and releases the core from reset.
- A reload request returns to loading from address 0.

Parameters:
- ADDR_W, 12, RAM address width (MU0 4K-word space).
- DATA_W, 16, word width.
- Derived, not overridable: MAX_ADDR = 2^ADDR_W - 1.

Ports:
- clock  input  1  system clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- word_in  input  DATA_W  assembled word from the combining stage.
- word_valid  input  1  word_in is valid this cycle; held until accepted.
- word_ready  output  1  loader accepts word_in at this edge if word_valid=1.
- run_req  input  1  level request to start the core.
- reload  input  1  single-cycle request to restart loading (honoured only in RUN).
- mem_addr  output  ADDR_W  RAM write address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_we  output  1  RAM write strobe, one cycle per word.
- mem_sel  output  1  1 = loader owns the RAM port, 0 = core owns it.
- cpu_reset  output  1  active-high reset to the MU0 core.
- word_count  output  ADDR_W+1  number of words written since the last load start.
- full  output  1  all 2^ADDR_W locations written.

Behaviour:
- All outputs are registered.
- Reset values:
  - State LOAD.
  - wptr=0, mem_addr=0, mem_wdata=0, mem_we=0, word_count=0, full=0.
  - mem_sel=1, cpu_reset=1, word_ready=1.
- Reset mid-write aborts the write; mem_we falls immediately with the asynchronous reset.
- States: LOAD, WRITE, RUN.
- LOAD:
  - word_ready = ~full.
  - When word_valid & word_ready at an edge: capture word_in into mem_wdata, mem_addr<=wptr, mem_we<=1, word_ready<=0, go to WRITE.
  - Else if run_req=1: go to RUN.
  - A word and run_req in the same cycle: the word wins; run_req is re-evaluated after the write. run_req is a level, so a held request still starts the core.
- WRITE (exactly one cycle):
  - mem_we=1, word_ready=0.
  - At the edge: mem_we<=0, word_count<=word_count+1.
  - If wptr==MAX_ADDR: full<=1 and wptr holds. Else wptr<=wptr+1.
  - Return to LOAD; word_ready<=~full_next.
- Throughput is one word per 2 cycles. Latency is acceptance edge N -> mem_we high during cycle N+1 with the captured address/data.
- Full:
  - While full=1, word_ready=0 and word_valid is ignored; no wrap, address MAX_ADDR is never overwritten.
  - run_req still works.
- Entering RUN (edge out of LOAD):
  - cpu_reset<=0, mem_sel<=0, word_ready<=0, mem_we stays 0.
  - word_count and full hold their values.
- RUN with zero words written is legal.
- RUN:
  - word_valid and run_req are ignored.
  - When reload=1: go to LOAD with wptr=0, word_count=0, full=0, cpu_reset<=1, mem_sel<=1, word_ready<=1.
  - cpu_reset and mem_sel change on the same edge; the core is never out of reset while mem_sel=1.
- reload in LOAD or WRITE is ignored.
- word_count is ADDR_W+1 bits so it reaches 4096 without overflow.

Test Plan:
- Reset then stream words 16'h0005, 16'h2006, 16'h7000 (word_valid held, waiting on word_ready) -> mem_we pulses three times, one cycle each, at addresses 0, 1, 2 with those data; word_ready low exactly in each WRITE cycle; word_count=3.
- word_valid=1 with 16'h1234 and run_req=1 on the same edge in LOAD -> 16'h1234 written to address 0 first; cpu_reset falls and mem_sel=0 on the following edge; word_count=1.
- Feed 4097 words (ADDR_W=12) -> the 4096th word is written at 12'hFFF; full=1 and word_ready=0 afterwards; the 4097th is never accepted; word_count=4096; run_req then enters RUN.
- In RUN, toggle word_valid with 16'hFFFF and pulse run_req -> no mem_we, cpu_reset stays 0. Pulse reload -> cpu_reset=1, mem_sel=1, word_count=0, full=0; the next word writes address 0.
- Assert reset during WRITE (mem_we=1 at address 7) -> mem_we=0 and all outputs at reset values immediately without waiting for a clock; the next accepted word writes address 0.
